// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard receiver, E0/F0 prefix decoder, modifier tracking and FWFT event FIFO on one clock.
// Optional auto-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_fifo #(
  parameter int DEPTH          = 16,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                       i_clk,
  input  logic                       i_clrn,
  input  logic                       i_ps2_clk,
  input  logic                       i_ps2_data,
  input  logic                       i_rd_en,
  input  logic                       i_ovf_clr,
  output logic [9:0]                 o_ev_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic                       o_frame_err,
  output logic [3:0]                 o_mod_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LOAD_C = TW'(TIMEOUT_CYCLES - 1);

  // state   | meaning
  // IDLE    | no prefix pending
  // EXT     | E0 received
  // BRK     | F0 received
  // EXTBRK  | E0 F0 received
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} dec_state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic [3:0]             r_bit_cnt;
  logic [10:0]            r_shift;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_byte_vld;
  logic [7:0]             r_byte;
  logic                   r_frame_err;

  logic                   w_fall, w_data_bit, w_last_bit, w_frame_ok, w_timeout;
  logic [10:0]            w_frame;

  assign w_fall     = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_data_bit = r_data_sync[SYNC_STAGES-1];
  assign w_frame    = {w_data_bit, r_shift[10:1]};
  assign w_last_bit = w_fall && (r_bit_cnt == 4'd10);
  assign w_frame_ok = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);
  assign w_timeout  = !w_fall && (r_bit_cnt != 4'd0) && (r_to_cnt == '0);

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_shift  <= w_frame;
        r_to_cnt <= TO_LOAD_C;
        if (w_last_bit) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_byte_vld <= 1'b1;
            r_byte     <= w_frame[8:1];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (w_timeout) begin
        r_bit_cnt   <= '0;
        r_frame_err <= 1'b1;
      end else if (r_bit_cnt != 4'd0) begin
        r_to_cnt <= r_to_cnt - TW'(1);
      end
    end
  end

  assign o_frame_err = r_frame_err;

  dec_state_t r_state, w_state_nxt;
  logic       w_emit, w_brk, w_ext, w_drop, w_emit_ok, w_discard;
  logic       r_push;
  logic [9:0] r_push_data;
  logic [3:0] r_mods;

  assign w_discard = (r_byte == 8'hE1) || (r_byte == 8'h00) || (r_byte == 8'hFF) ||
                     (r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hEE) ||
                     (r_byte == 8'hFC);

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (r_byte_vld) begin
      if (w_discard) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_byte == 8'hE0)      w_state_nxt = ST_EXT;
            else if (r_byte == 8'hF0) w_state_nxt = ST_BRK;
            else                      w_emit = 1'b1;
          end
          ST_EXT: begin
            if (r_byte == 8'hF0) begin
              w_state_nxt = ST_EXTBRK;
            end else begin
              w_emit      = 1'b1;
              w_ext       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            w_emit      = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
          default: begin
            w_emit      = 1'b1;
            w_brk       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_last_vld;
  logic [8:0] r_last_key;

  assign w_drop = w_emit && !w_brk && r_last_vld && (r_last_key == {w_ext, r_byte});

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_last_vld <= 1'b0;
      r_last_key <= '0;
    end else if (w_emit) begin
      if (!w_brk) begin
        r_last_vld <= 1'b1;
        r_last_key <= {w_ext, r_byte};
      end else if (r_last_key == {w_ext, r_byte}) begin
        r_last_vld <= 1'b0;
      end
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  assign w_emit_ok = w_emit && !w_drop;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state     <= ST_IDLE;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_mods      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_push      <= w_emit_ok;
      r_push_data <= {w_brk, w_ext, r_byte};
      if (w_emit_ok) begin
        if (r_byte == 8'h12 || r_byte == 8'h59) r_mods[0] <= !w_brk;
        if (r_byte == 8'h14)                    r_mods[1] <= !w_brk;
        if (r_byte == 8'h11)                    r_mods[2] <= !w_brk;
        if (r_byte == 8'h58 && !w_brk && !w_ext) r_mods[3] <= !r_mods[3];
      end
    end
  end

  assign o_mod_flags = r_mods;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full, w_empty, w_pop, w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = i_rd_en && !w_empty;
  // A push into a full FIFO only fits when the head leaves in the same cycle.
  assign w_push_ok = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_push_data;
  end

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (r_push && !w_push_ok) r_ovf <= 1'b1;
      else if (i_ovf_clr)       r_ovf <= 1'b0;
    end
  end

  assign o_ev_data  = r_mem[r_rptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_level    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: bit-banged PS/2 frames, hand-computed expected events.
// Expectations for the repeat test follow PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_key_event_fifo;

  localparam int DEPTH = 4;
  localparam int TO    = 300;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [9:0] ev_data;
  logic       empty, full, overflow, frame_err;
  logic [2:0] level;
  logic [3:0] mod_flags;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;

  ps2_key_event_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_clrn(clrn), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .i_rd_en(rd_en), .i_ovf_clr(ovf_clr), .o_ev_data(ev_data), .o_empty(empty),
    .o_full(full), .o_level(level), .o_overflow(overflow), .o_frame_err(frame_err),
    .o_mod_flags(mod_flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check_eq(tag, {22'd0, ev_data}, {22'd0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_mods", mod_flags, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    ps2_send(8'h1C, 0, 11);
    check_eq("a_level", level, 1);
    check_eq("a_mods", mod_flags, 0);
    pop_check("a_make", 10'h01C);
    check_eq("a_empty", empty, 1);

    ps2_send(8'hF0, 0, 11); ps2_send(8'h1C, 0, 11);
    check_eq("brk_level", level, 1);
    pop_check("a_break", 10'h21C);
    ps2_send(8'hE0, 0, 11); ps2_send(8'hF0, 0, 11); ps2_send(8'h75, 0, 11);
    check_eq("extbrk_level", level, 1);
    pop_check("up_extbrk", 10'h375);

    ps2_send(8'h12, 0, 11);
    check_eq("shift_set", mod_flags, 4'b0001);
    ps2_send(8'hF0, 0, 11); ps2_send(8'h12, 0, 11);
    check_eq("shift_clr", mod_flags, 4'b0000);
    check_eq("shift_level", level, 2);
    pop_check("shift_make", 10'h012);
    pop_check("shift_break", 10'h212);

    ps2_send(8'hE0, 0, 11); ps2_send(8'h14, 0, 11);
    check_eq("rctrl_mods", mod_flags, 4'b0010);
    pop_check("rctrl_make", 10'h114);
    ps2_send(8'hE0, 0, 11); ps2_send(8'hF0, 0, 11); ps2_send(8'h14, 0, 11);
    check_eq("rctrl_rel", mod_flags, 4'b0000);
    pop_check("rctrl_break", 10'h314);

    ps2_send(8'hAA, 0, 11);
    check_eq("discard_aa", empty, 1);

    e0 = err_cnt;
    ps2_send(8'h1C, 1, 11);
    check_eq("par_err", err_cnt - e0, 1);
    check_eq("par_noentry", empty, 1);

    e0 = err_cnt;
    ps2_send(8'h1C, 0, 5);
    repeat (TO + 20) @(negedge clk);
    check_eq("timeout_err", err_cnt - e0, 1);
    check_eq("timeout_noentry", empty, 1);
    ps2_send(8'h1C, 0, 11);
    check_eq("post_to_level", level, 1);
    pop_check("post_to_make", 10'h01C);

    ps2_send(8'h15, 0, 11); ps2_send(8'h16, 0, 11); ps2_send(8'h1A, 0, 11);
    ps2_send(8'h1B, 0, 11);
    check_eq("fill_ovf0", overflow, 0);
    ps2_send(8'h1D, 0, 11);
    check_eq("full", full, 1);
    check_eq("ovf_set", overflow, 1);
    check_eq("full_level", level, DEPTH);
    pop_check("rd0", 10'h015);
    pop_check("rd1", 10'h016);
    pop_check("rd2", 10'h01A);
    pop_check("rd3", 10'h01B);
    check_eq("drained", empty, 1);
    check_eq("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    check_eq("ovf_clr", overflow, 0);

    ps2_send(8'h58, 0, 11); ps2_send(8'h58, 0, 11); ps2_send(8'h58, 0, 11);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check_eq("caps_level", level, 1);
    check_eq("caps_on", mod_flags, 4'b1000);
    pop_check("caps_make", 10'h058);
`else
    check_eq("caps_level", level, 3);
    check_eq("caps_on", mod_flags, 4'b1000);
    pop_check("caps_make0", 10'h058);
    pop_check("caps_make1", 10'h058);
    pop_check("caps_make2", 10'h058);
`endif

    ps2_send(8'h12, 0, 11);
    ps2_send(8'h1C, 0, 4);
    clrn = 1'b0;
    #1;
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_mods", mod_flags, 0);
    check_eq("mid_rst_ferr", frame_err, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    ps2_send(8'h1C, 0, 11);
    check_eq("post_rst_level", level, 1);
    pop_check("post_rst_make", 10'h01C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
